// File: rtl/vga_timing_gen.sv
// Raster timing generator: divided pixel strobe, position counters, sync/blank decode, frame counter.
// Latency: every output is decoded from the same div/hpos/vpos registers, so all describe one pixel.
// Backpressure: none; free-running from reset.
module vga_timing_gen #(
    parameter int H_ADDR    = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ADDR    = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 1,
    parameter int W         = 10,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_stb,
    output logic [W-1:0]  hpos,
    output logic [W-1:0]  vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          hblank,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ADDR + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ADDR + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WX      = W + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [W-1:0]  H_LAST   = W'(H_TOTAL - 1);
    localparam logic [W-1:0]  V_LAST   = W'(V_TOTAL - 1);
    // One extra bit so a sync pulse ending exactly at TOTAL still compares correctly.
    localparam logic [WX-1:0] HB_START = WX'(H_ADDR);
    localparam logic [WX-1:0] HS_START = WX'(H_ADDR + H_FRONT);
    localparam logic [WX-1:0] HS_END   = WX'(H_ADDR + H_FRONT + H_SYNC);
    localparam logic [WX-1:0] VB_START = WX'(V_ADDR);
    localparam logic [WX-1:0] VS_START = WX'(V_ADDR + V_FRONT);
    localparam logic [WX-1:0] VS_END   = WX'(V_ADDR + V_FRONT + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [W-1:0]  hpos_q, hpos_d;
    logic [W-1:0]  vpos_q, vpos_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          h_wrap, v_wrap;
    logic [WX-1:0] hpos_x, vpos_x;
    logic          hs_act, vs_act;

    assign pix_stb = (div_q == DIV_LAST);
    assign h_wrap  = (hpos_q == H_LAST);
    assign v_wrap  = (vpos_q == V_LAST);

    always_comb begin
        div_d  = pix_stb ? '0 : div_q + DW'(1);
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        fcnt_d = fcnt_q;
        if (pix_stb) begin
            if (h_wrap) begin
                hpos_d = '0;
                if (v_wrap) begin
                    vpos_d = '0;
                    fcnt_d = fcnt_q + FW'(1);
                end else begin
                    vpos_d = vpos_q + W'(1);
                end
            end else begin
                hpos_d = hpos_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            hpos_q <= '0;
            vpos_q <= '0;
            fcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign hpos_x = {1'b0, hpos_q};
    assign vpos_x = {1'b0, vpos_q};

    assign hblank      = (hpos_x >= HB_START);
    assign vblank      = (vpos_x >= VB_START);
    assign display_on  = ~hblank & ~vblank;
    assign hs_act      = (hpos_x >= HS_START) && (hpos_x < HS_END);
    assign vs_act      = (vpos_x >= VS_START) && (vpos_x < VS_END);
    assign hsync       = hs_act ~^ HSYNC_POL;
    assign vsync       = vs_act ~^ VSYNC_POL;
    assign line_start  = (hpos_q == '0) && (div_q == '0);
    assign frame_start = line_start && (vpos_q == '0);

    assign hpos      = hpos_q;
    assign vpos      = vpos_q;
    assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Four raster configurations run side by side; stimulus queues expected reset/line/frame
// records, per-instance monitors measure each line/frame at the strobe and pop-compare.
module tb_vga_timing_gen;
    localparam int N = 4;
    localparam bit [N-1:0] HPOL = 4'b0100;
    localparam bit [N-1:0] VPOL = 4'b0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [N];
    logic       stb [N];
    logic       hs  [N];
    logic       vs  [N];
    logic       de  [N];
    logic       hb  [N];
    logic       vb  [N];
    logic       ls  [N];
    logic       fs  [N];
    logic [9:0] hp  [N];
    logic [9:0] vp  [N];
    logic [7:0] fc  [N];
    logic [1:0] fc2;

    assign fc[2] = {6'd0, fc2};

    int n_chk  = 0;
    int n_fail = 0;

    int rst_q   [N][$];
    int line_q  [N][$];
    int frame_q [N][$];

    string RST_NM [11] = '{"rst_hpos", "rst_vpos", "rst_hsync", "rst_vsync", "rst_display_on",
                           "rst_hblank", "rst_vblank", "rst_line_start", "rst_frame_start",
                           "rst_frame_cnt", "rst_pix_stb"};
    string LN_NM  [10] = '{"line_clks", "line_pix_stb", "line_start_clks", "hsync_clks",
                           "hsync_first_hpos", "hsync_last_hpos", "display_off_hpos",
                           "hblank_hpos", "last_pixel_hold", "next_vpos"};
    string FR_NM  [11] = '{"frame_clks", "vsync_clks", "vsync_first_vpos", "vsync_last_vpos",
                           "vsync_first_hpos", "vblank_clks", "vblank_first_vpos",
                           "frame_start_clks", "frame_cnt", "frame_hpos", "frame_vpos"};

    // default timing
    vga_timing_gen u0 (
        .clk(clk), .reset(rst[0]), .pix_stb(stb[0]), .hpos(hp[0]), .vpos(vp[0]),
        .hsync(hs[0]), .vsync(vs[0]), .display_on(de[0]), .hblank(hb[0]), .vblank(vb[0]),
        .line_start(ls[0]), .frame_start(fs[0]), .frame_cnt(fc[0])
    );

    vga_timing_gen #(.V_ADDR(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)) u1 (
        .clk(clk), .reset(rst[1]), .pix_stb(stb[1]), .hpos(hp[1]), .vpos(vp[1]),
        .hsync(hs[1]), .vsync(vs[1]), .display_on(de[1]), .hblank(hb[1]), .vblank(vb[1]),
        .line_start(ls[1]), .frame_start(fs[1]), .frame_cnt(fc[1])
    );

    vga_timing_gen #(.H_ADDR(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                     .V_ADDR(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FW(2)) u2 (
        .clk(clk), .reset(rst[2]), .pix_stb(stb[2]), .hpos(hp[2]), .vpos(vp[2]),
        .hsync(hs[2]), .vsync(vs[2]), .display_on(de[2]), .hblank(hb[2]), .vblank(vb[2]),
        .line_start(ls[2]), .frame_start(fs[2]), .frame_cnt(fc2)
    );

    vga_timing_gen #(.V_ADDR(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3)) u3 (
        .clk(clk), .reset(rst[3]), .pix_stb(stb[3]), .hpos(hp[3]), .vpos(vp[3]),
        .hsync(hs[3]), .vsync(vs[3]), .display_on(de[3]), .hblank(hb[3]), .vblank(vb[3]),
        .line_start(ls[3]), .frame_start(fs[3]), .frame_cnt(fc[3])
    );

    task automatic chk(input int g, input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0d, expected %0d", g, nm, act, exp);
        end
    endtask

    task automatic push_rst(input int g, input int hs0, input int vs0, input int stb0);
        int r [11];
        r = '{0, 0, hs0, vs0, 1, 0, 0, 1, 1, 0, stb0};
        for (int i = 0; i < 11; i++) rst_q[g].push_back(r[i]);
    endtask

    task automatic push_line(input int g, input int len, input int nstb, input int hsc,
                             input int hsf, input int hsl, input int deoff, input int hbon,
                             input int hold, input int vnext);
        int r [10];
        r = '{len, nstb, 1, hsc, hsf, hsl, deoff, hbon, hold, vnext};
        for (int i = 0; i < 10; i++) line_q[g].push_back(r[i]);
    endtask

    task automatic push_frame(input int g, input int len, input int vsc, input int vsf,
                              input int vsl, input int vbc, input int vbf, input int cnt);
        int r [11];
        r = '{len, vsc, vsf, vsl, 0, vbc, vbf, 1, cnt, 0, 0};
        for (int i = 0; i < 11; i++) frame_q[g].push_back(r[i]);
    endtask

    function automatic bit all_empty();
        for (int g = 0; g < N; g++)
            if (rst_q[g].size() != 0 || line_q[g].size() != 0 || frame_q[g].size() != 0)
                return 1'b0;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_mon
        bit         rst_p    = 1'b0;
        bit         rst_seen = 1'b0;
        bit         ln_ok    = 1'b0;
        bit         fr_ok    = 1'b0;
        bit         hs_a, vs_a;
        int         run      = 0;
        int         last_run = 0;
        logic [9:0] prev_hp  = '0;
        int         ln [10];
        int         fr [11];
        int         rr [11];

        always @(posedge clk) rst_p <= rst[g];

        always @(negedge clk) begin
            hs_a = (hs[g] === HPOL[g]);
            vs_a = (vs[g] === VPOL[g]);
            if (hp[g] !== prev_hp) begin
                last_run = run;
                run = 1;
            end else begin
                run++;
            end
            prev_hp = hp[g];

            if (rst_p && !rst_seen && rst_q[g].size() >= 11) begin
                rr = '{int'(hp[g]), int'(vp[g]), int'(hs[g]), int'(vs[g]), int'(de[g]),
                       int'(hb[g]), int'(vb[g]), int'(ls[g]), int'(fs[g]), int'(fc[g]),
                       int'(stb[g])};
                for (int i = 0; i < 11; i++) chk(g, RST_NM[i], rr[i], rst_q[g].pop_front());
            end
            rst_seen = rst_p;

            // Line record closes on each line_start; a reset cycle opens a fresh line.
            ln[8] = last_run;
            ln[9] = int'(vp[g]);
            if (ls[g] === 1'b1 && !rst_p && ln_ok && line_q[g].size() >= 10)
                for (int i = 0; i < 10; i++) chk(g, LN_NM[i], ln[i], line_q[g].pop_front());
            if (ls[g] === 1'b1 || rst_p) begin
                for (int i = 0; i < 4; i++) ln[i] = 0;
                for (int i = 4; i < 8; i++) ln[i] = -1;
                ln_ok = 1'b1;
            end
            ln[0]++;
            if (stb[g] === 1'b1) ln[1]++;
            if (ls[g] === 1'b1) ln[2]++;
            if (hs_a) begin
                ln[3]++;
                if (ln[4] < 0) ln[4] = int'(hp[g]);
                ln[5] = int'(hp[g]);
            end
            if (de[g] === 1'b0 && ln[6] < 0) ln[6] = int'(hp[g]);
            if (hb[g] === 1'b1 && ln[7] < 0) ln[7] = int'(hp[g]);

            fr[8]  = int'(fc[g]);
            fr[9]  = int'(hp[g]);
            fr[10] = int'(vp[g]);
            if (fs[g] === 1'b1 && !rst_p && fr_ok && frame_q[g].size() >= 11)
                for (int i = 0; i < 11; i++) chk(g, FR_NM[i], fr[i], frame_q[g].pop_front());
            if (fs[g] === 1'b1 || rst_p) begin
                fr[0] = 0; fr[1] = 0; fr[5] = 0; fr[7] = 0;
                fr[2] = -1; fr[3] = -1; fr[4] = -1; fr[6] = -1;
                fr_ok = 1'b1;
            end
            fr[0]++;
            if (vs_a) begin
                fr[1]++;
                if (fr[2] < 0) begin
                    fr[2] = int'(vp[g]);
                    fr[4] = int'(hp[g]);
                end
                fr[3] = int'(vp[g]);
            end
            if (vb[g] === 1'b1) begin
                fr[5]++;
                if (fr[6] < 0) fr[6] = int'(vp[g]);
            end
            if (fs[g] === 1'b1) fr[7]++;
        end
    end

    initial begin
        int cyc;
        for (int g = 0; g < N; g++) rst[g] = 1'b1;

        push_rst(0, 1, 1, 1);
        push_rst(1, 1, 1, 0);
        push_rst(2, 0, 0, 1);
        push_rst(3, 1, 1, 0);

        for (int v = 1; v <= 3; v++) begin
            push_line(0,  800, 800, 96,  656, 751, 640, 640, 1, v);
            push_line(1, 1600, 800, 192, 656, 751, 640, 640, 2, v);
        end
        for (int v = 0; v < 6; v++)
            push_line(2, 7, 7, 1, 5, 5, (v < 3) ? 4 : 0, 4, 1, (v + 1) % 6);

        push_frame(1, 22400, 3200, 10, 11, 9600, 8, 1);
        push_frame(1, 22400, 3200, 10, 11, 9600, 8, 2);
        push_frame(2, 42, 7, 4, 4, 21, 3, 1);
        push_frame(2, 42, 7, 4, 4, 21, 3, 2);
        push_frame(2, 42, 7, 4, 4, 21, 3, 3);
        push_frame(2, 42, 7, 4, 4, 21, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) rst[g] = 1'b0;

        // Pulse u3 reset while it sits on pixel (700,5) with div=1.
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(hp[3] == 10'd700 && vp[3] == 10'd5) && cyc < 20000);
        if (!(hp[3] == 10'd700 && vp[3] == 10'd5)) begin
            n_chk++;
            n_fail++;
            $display("FAIL u3 reach_700_5: got hpos %0d vpos %0d after %0d cycles, expected 700/5",
                     hp[3], vp[3], cyc);
        end else begin
            push_rst(3, 1, 1, 0);
            push_line(3, 2400, 800, 288, 656, 751, 640, 640, 3, 1);
            push_line(3, 2400, 800, 288, 656, 751, 640, 640, 3, 2);
            @(posedge clk);
            #1 rst[3] = 1'b1;
            @(posedge clk);
            #1 rst[3] = 1'b0;
        end

        cyc = 0;
        while (!all_empty() && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        for (int g = 0; g < N; g++) begin
            n_chk++;
            if (rst_q[g].size() != 0 || line_q[g].size() != 0 || frame_q[g].size() != 0) begin
                n_fail++;
                $display("FAIL u%0d drain: pending rst/line/frame words %0d/%0d/%0d, expected 0/0/0",
                         g, rst_q[g].size(), line_q[g].size(), frame_q[g].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
